vga_mem_port_arbiter: RTL

- Owns the single read port (port B) of the shared CPU/VGA RAM and splits it between two requesters.
- Video requester: the sprite pixel fetch path. It has absolute priority and issues one address per cycle with fixed latency.
- Aux requester: a burst read engine that pulls a block of words, such as sprite position words, and sequences the addresses itself. It only uses cycles the video path leaves idle.
- Sits between the VGA top level and RAM port B, replacing ad-hoc address muxing.

---
 rtl/vga_mem_port_arbiter_if.sv | 40 ++++
 rtl/vga_mem_port_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/vga_mem_port_arbiter_if.sv
// Port-B bundle between the VGA requesters, the shared RAM read port and the arbiter.
// slave: arbiter side; master: requesters plus RAM side.
interface vga_mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 8
);
    localparam int unsigned DATA_WIDTH = 16;

    logic                  vid_req;
    logic [ADDR_WIDTH-1:0] vid_addr;
    logic                  vid_rvalid;

    logic                  aux_start;
    logic [ADDR_WIDTH-1:0] aux_base;
    logic [LEN_WIDTH-1:0]  aux_len;
    logic                  aux_window;
    logic                  aux_busy;
    logic                  aux_rvalid;
    logic [LEN_WIDTH-1:0]  aux_rindex;
    logic                  aux_done;
    logic                  aux_starve;

    logic [ADDR_WIDTH-1:0] ram_addr_b;
    logic                  ram_we_b;
    logic [DATA_WIDTH-1:0] ram_dout_b;
    logic [DATA_WIDTH-1:0] ram_q_b;
    logic [DATA_WIDTH-1:0] rdata;

    modport slave (
        input  vid_req, vid_addr, aux_start, aux_base, aux_len, aux_window, ram_q_b,
        output vid_rvalid, aux_busy, aux_rvalid, aux_rindex, aux_done, aux_starve,
               ram_addr_b, ram_we_b, ram_dout_b, rdata
    );

    modport master (
        output vid_req, vid_addr, aux_start, aux_base, aux_len, aux_window, ram_q_b,
        input  vid_rvalid, aux_busy, aux_rvalid, aux_rindex, aux_done, aux_starve,
               ram_addr_b, ram_we_b, ram_dout_b, rdata
    );
endinterface

// File: rtl/vga_mem_port_arbiter.sv
// RAM port-B arbiter: video fetch has absolute priority, aux burst engine uses idle slots.
// Optional ARB_VBLANK_GATE_EN restricts aux issues to cycles with aux_window=1.
module vga_mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned LEN_WIDTH    = 8,
    parameter int unsigned STARVE_LIMIT = 1024
) (
    input logic                   sys_clk,
    input logic                   reset,
    vga_mem_port_arbiter_if.slave bus
);
    localparam int unsigned DATA_WIDTH  = 16;
    localparam int unsigned STALL_WIDTH = $clog2(STARVE_LIMIT + 1);
    localparam logic [STALL_WIDTH-1:0] STALL_LIMIT = STALL_WIDTH'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_AUX} tag_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
    logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
    logic [LEN_WIDTH-1:0]   issued_q, issued_d;
    tag_t                   tag1_q, tag1_d;
    logic [LEN_WIDTH-1:0]   idx1_q, idx1_d;
    logic                   vid_rvalid_q, aux_rvalid_q;
    logic [LEN_WIDTH-1:0]   rindex_q;
    logic [STALL_WIDTH-1:0] stall_q, stall_d;
    logic                   starve_q, starve_d;
    logic                   done_q, done_d;
    logic                   gate_open;
    logic                   issue;

`ifdef ARB_VBLANK_GATE_EN
    assign gate_open = bus.aux_window;
`else
    logic unused_window;
    assign unused_window = bus.aux_window;
    assign gate_open     = 1'b1;
`endif

    // Slot arbitration, burst sequencing and stall accounting
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        issued_d    = issued_q;
        tag1_d      = TAG_NONE;
        idx1_d      = idx1_q;
        stall_d     = '0;
        done_d      = 1'b0;
        issue       = (state_q == S_BURST) && !bus.vid_req && gate_open;

        if (bus.vid_req) begin
            addr_d = bus.vid_addr;
            tag1_d = TAG_VID;
        end else if (issue) begin
            addr_d   = ptr_q;
            tag1_d   = TAG_AUX;
            idx1_d   = issued_q;
            ptr_d    = ptr_q + ADDR_WIDTH'(1);
            issued_d = issued_q + LEN_WIDTH'(1);
        end

        if ((state_q == S_BURST) && !issue) begin
            stall_d = (stall_q >= STALL_LIMIT) ? stall_q : stall_q + STALL_WIDTH'(1);
        end
        starve_d = (stall_d >= STALL_LIMIT);

        case (state_q)
            S_IDLE: begin
                if (bus.aux_start) begin
                    if (bus.aux_len != '0) begin
                        state_d     = S_BURST;
                        ptr_d       = bus.aux_base;
                        remaining_d = bus.aux_len;
                        issued_d    = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_BURST: begin
                if (issue && (issued_q == remaining_q - LEN_WIDTH'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Last aux tag is in stage 1 on the first drain cycle
                if (tag1_q == TAG_AUX) begin
                    done_d = 1'b1;
                end
                if (done_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            ptr_q        <= '0;
            remaining_q  <= '0;
            issued_q     <= '0;
            tag1_q       <= TAG_NONE;
            idx1_q       <= '0;
            vid_rvalid_q <= 1'b0;
            aux_rvalid_q <= 1'b0;
            rindex_q     <= '0;
            stall_q      <= '0;
            starve_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            ptr_q        <= ptr_d;
            remaining_q  <= remaining_d;
            issued_q     <= issued_d;
            tag1_q       <= tag1_d;
            idx1_q       <= idx1_d;
            vid_rvalid_q <= (tag1_q == TAG_VID);
            aux_rvalid_q <= (tag1_q == TAG_AUX);
            if (tag1_q == TAG_AUX) begin
                rindex_q <= idx1_q;
            end
            stall_q      <= stall_d;
            starve_q     <= starve_d;
            done_q       <= done_d;
        end
    end

    assign bus.ram_addr_b = addr_q;
    assign bus.ram_we_b   = 1'b0;
    assign bus.ram_dout_b = DATA_WIDTH'(0);
    assign bus.rdata      = bus.ram_q_b;
    assign bus.vid_rvalid = vid_rvalid_q;
    assign bus.aux_rvalid = aux_rvalid_q;
    assign bus.aux_rindex = rindex_q;
    assign bus.aux_done   = done_q;
    assign bus.aux_busy   = (state_q != S_IDLE);
    assign bus.aux_starve = starve_q;
endmodule
